// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR control slice.
//   fir_state_t    : control FSM encoding (IDLE=0, RUN=1)
//   FIR_TAPS       : default filter length (power of two, >= 2)
//   FIR_DATA_WIDTH : default sample width in bits
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_TAPS       = 8;
  localparam int FIR_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fir_state_t;

endpackage : fir_pkg

// File: rtl/fir_sample_buffer.sv
// -----------------------------------------------------------------------------
// fir_sample_buffer
// Circular sample history for the FIR control unit: one synchronous write
// port, one asynchronous (combinational) read port, and an asynchronous
// clear of every entry on reset so unwritten history reads as zero.
//   clock    : sole clock
//   reset    : asynchronous, active-high; clears all entries
//   wr_en    : write x into mem[wr_addr] at the rising edge
//   wr_addr  : write index
//   wr_data  : write data
//   rd_addr  : read index
//   rd_data  : mem[rd_addr], combinational
// -----------------------------------------------------------------------------
module fir_sample_buffer #(
  parameter  int data_width = 8,
  parameter  int depth      = 8,
  localparam int AW         = $clog2(depth)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem_reg [depth];

  // Register array rather than block RAM: the whole history must clear
  // in one reset event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule : fir_sample_buffer

// File: rtl/fir_control_unit.sv
// -----------------------------------------------------------------------------
// fir_control_unit
// Sequences one FIR output per accepted sample: stores the sample in a
// circular history, then issues taps (coefficient index, delayed sample)
// pairs, one per cycle, to a downstream MAC.
//   clock       : sole clock, rising edge
//   reset       : asynchronous, active-high
//   bypass      : (only with FIR_CTRL_BYPASS_EN) single-tap pass-through frame
//   x_in        : input sample
//   valid_in    : x_in valid; only honoured while ready_out=1
//   ready_out   : 1 in IDLE, 0 in RUN
//   rom_address : coefficient index k (registered)
//   ram_out     : x[n-k] in RUN, 0 in IDLE (combinational)
//   mac_init    : 1 on the k=0 cycle of a frame (registered)
//   frame_done  : one-cycle pulse after the last tap of a frame
// Optional feature macro: FIR_CTRL_BYPASS_EN adds the bypass input.
// -----------------------------------------------------------------------------
module fir_control_unit
  import fir_pkg::*;
#(
  parameter  int data_width = FIR_DATA_WIDTH,
  parameter  int taps       = FIR_TAPS,
  localparam int AW         = $clog2(taps)
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef FIR_CTRL_BYPASS_EN
  input  logic                  bypass,
`endif
  input  logic [data_width-1:0] x_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [AW-1:0]         rom_address,
  output logic [data_width-1:0] ram_out,
  output logic                  mac_init,
  output logic                  frame_done
);

  localparam logic [AW-1:0] LAST_K = AW'(taps - 1);

  fir_state_t      state_reg, state_next;
  logic [AW-1:0]   k_reg, k_next;
  logic [AW-1:0]   newest_reg, newest_next;
  logic [AW-1:0]   wptr_reg, wptr_next;
  logic            mac_init_reg, mac_init_next;
  logic            frame_done_reg, frame_done_next;
  logic            wr_en;
  logic            last_tap;
  logic [data_width-1:0] rd_data;

`ifdef FIR_CTRL_BYPASS_EN
  // Remembers that the current frame is a single-tap bypass frame.
  logic bypass_frame_reg, bypass_frame_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) bypass_frame_reg <= 1'b0;
    else       bypass_frame_reg <= bypass_frame_next;
  end

  assign last_tap = (k_reg == LAST_K) || bypass_frame_reg;
`else
  assign last_tap = (k_reg == LAST_K);
`endif

  fir_sample_buffer #(
    .data_width (data_width),
    .depth      (taps)
  ) u_buffer (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wptr_reg),
    .wr_data (x_in),
    // AW-bit subtraction wraps modulo taps because taps is a power of two.
    .rd_addr (newest_reg - k_reg),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      newest_reg     <= '0;
      wptr_reg       <= '0;
      mac_init_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      newest_reg     <= newest_next;
      wptr_reg       <= wptr_next;
      mac_init_reg   <= mac_init_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    k_next          = k_reg;
    newest_next     = newest_reg;
    wptr_next       = wptr_reg;
    mac_init_next   = 1'b0;
    frame_done_next = 1'b0;
    wr_en           = 1'b0;
`ifdef FIR_CTRL_BYPASS_EN
    bypass_frame_next = bypass_frame_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (valid_in) begin
          wr_en         = 1'b1;
          newest_next   = wptr_reg;
          k_next        = '0;
          mac_init_next = 1'b1;
          state_next    = RUN;
`ifdef FIR_CTRL_BYPASS_EN
          bypass_frame_next = bypass;
`endif
        end
      end
      RUN: begin
        if (last_tap) begin
          // k returns to 0 so rom_address reads 0 throughout IDLE.
          state_next      = IDLE;
          k_next          = '0;
          wptr_next       = wptr_reg + AW'(1);
          frame_done_next = 1'b1;
`ifdef FIR_CTRL_BYPASS_EN
          bypass_frame_next = 1'b0;
`endif
        end else begin
          k_next = k_reg + AW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready_out   = (state_reg == IDLE);
  assign rom_address = k_reg;
  assign mac_init    = mac_init_reg;
  assign frame_done  = frame_done_reg;
  // Zero in IDLE so the accumulator adds nothing between frames.
  assign ram_out     = (state_reg == RUN) ? rd_data : '0;

endmodule : fir_control_unit

// File: tb/tb_fir_control_unit.sv
// Self-checking bench for fir_control_unit: a reference history model
// pushes the expected (k, x[n-k], mac_init) sequence for each accepted
// sample into a queue; the negedge monitor pops and compares every RUN cycle.
module tb_fir_control_unit;

  localparam int W  = 8;
  localparam int T  = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] k;
    logic [W-1:0]  d;
    logic          mi;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic [W-1:0]  x_in = '0;
  logic          bypass_drv = 1'b0;
  logic          ready_out;
  logic [AW-1:0] rom_address;
  logic [W-1:0]  ram_out;
  logic          mac_init;
  logic          frame_done;

  fir_control_unit #(.data_width(W), .taps(T)) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef FIR_CTRL_BYPASS_EN
    .bypass      (bypass_drv),
`endif
    .x_in        (x_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .rom_address (rom_address),
    .ram_out     (ram_out),
    .mac_init    (mac_init),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  // Reference model state
  exp_t         q[$];
  logic [W-1:0] hist [T];
  int           wp = 0;
  int           run_left = 0;
  logic         pending_fd = 1'b0;
  int           checks = 0;
  int           errors = 0;
  exp_t         e;
  logic         exp_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] x, input logic byp);
    exp_t t;
    hist[wp] = x;
    if (byp) begin
      t.k = '0; t.d = x; t.mi = 1'b1;
      q.push_back(t);
      run_left = 1;
    end else begin
      for (int k = 0; k < T; k++) begin
        t.k  = AW'(k);
        t.d  = hist[(wp - k + T) % T];
        t.mi = (k == 0);
        q.push_back(t);
      end
      run_left = T;
    end
    wp = (wp + 1) % T;
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < T; i++) hist[i] = '0;
    wp = 0;
    run_left = 0;
    pending_fd = 1'b0;
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_ready = (run_left == 0);
    check("ready_out", 32'(ready_out), 32'(exp_ready));
    check("frame_done", 32'(frame_done), 32'(pending_fd));
    pending_fd = 1'b0;
    if (!exp_ready) begin
      if (q.size() == 0) begin
        check("queue_nonempty_in_run", 32'(q.size()), 32'd1);
        run_left = 0;
      end else begin
        e = q.pop_front();
        $display("tap k=%0d ram_out=%0d mac_init=%0d", rom_address, ram_out, mac_init);
        check("rom_address", 32'(rom_address), 32'(e.k));
        check("ram_out", 32'(ram_out), 32'(e.d));
        check("mac_init", 32'(mac_init), 32'(e.mi));
        run_left--;
        if (run_left == 0) pending_fd = 1'b1;
      end
    end else begin
      check("idle_rom_address", 32'(rom_address), 32'd0);
      check("idle_ram_out", 32'(ram_out), 32'd0);
      check("idle_mac_init", 32'(mac_init), 32'd0);
    end
    if (exp_ready && valid_in && !reset) begin
      $display("accept x_in=%0d bypass=%0d", x_in, bypass_drv);
      push_frame(x_in, bypass_drv);
    end
  end

  task automatic check_reset_outputs();
    check("rst_ready_out", 32'(ready_out), 32'd1);
    check("rst_rom_address", 32'(rom_address), 32'd0);
    check("rst_ram_out", 32'(ram_out), 32'd0);
    check("rst_mac_init", 32'(mac_init), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    clear_model();
    #1;
    check_reset_outputs();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Waits (bounded) for ready_out, then presents one sample for one cycle.
  task automatic send(input logic [W-1:0] x, input logic byp);
    int n = 0;
    @(posedge clock); #1;
    while (ready_out !== 1'b1 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 40) check("ready_timeout_cycles", 32'(n), 32'd0);
    valid_in   = 1'b1;
    x_in       = x;
    bypass_drv = byp;
    @(posedge clock); #1;
    valid_in   = 1'b0;
    bypass_drv = 1'b0;
  endtask

  task automatic drain();
    repeat (T + 4) @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    clear_model();
    #2;
    check_reset_outputs();
    @(posedge clock); #1;
    reset = 1'b0;

    // Single sample after reset: 5,0,0,...
    send(8'd5, 1'b0);
    drain();

    // Back-to-back 1,2,3 at maximum throughput
    do_reset();
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    drain();

    // Ten samples: write pointer wraps
    do_reset();
    for (int i = 1; i <= 10; i++) send(W'(i), 1'b0);
    drain();

    // valid_in held through RUN: 7 then 9, one write per frame
    do_reset();
    @(posedge clock); #1;
    valid_in = 1'b1;
    x_in     = 8'd7;
    @(posedge clock); #1;
    x_in = 8'd9;
    n = 0;
    while (ready_out !== 1'b1 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 40) check("ready_timeout_cycles", 32'(n), 32'd0);
    @(posedge clock); #1;
    valid_in = 1'b0;
    drain();

    // Reset at k=3 aborts the frame; history is cleared
    do_reset();
    send(8'd2, 1'b0);
    repeat (2) @(posedge clock);
    do_reset();
    send(8'd4, 1'b0);
    drain();

`ifdef FIR_CTRL_BYPASS_EN
    // Bypass frame still writes history and advances the write pointer
    do_reset();
    send(8'd6, 1'b1);
    send(8'd8, 1'b0);
    drain();
`endif

    check("queue_drained", 32'(q.size()), 32'd0);
    check("run_left_zero", 32'(run_left), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fir_control_unit

// File: doc/fir_control_unit.md
FIR_CONTROL_UNIT -- requirements
Module: fir_control_unit

Interface
REQ-001 Parameter data_width, default 8, sample width in bits.
REQ-002 Parameter taps, default 8, filter length; power of two, at least 2.
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port x_in  input  data_width  new input sample.
REQ-006 Port valid_in  input  1  x_in valid this cycle.
REQ-007 Port ready_out  output  1  block can accept a sample this cycle.
REQ-008 Port rom_address  output  log2(taps)  coefficient index for the coefficient ROM.
REQ-009 Port ram_out  output  data_width  delayed sample paired with rom_address, for the downstream MAC.
REQ-010 Port mac_init  output  1  first product of a frame; MAC restarts its accumulator.
REQ-011 Port frame_done  output  1  one-cycle pulse after the last tap of a frame is issued.

Function
REQ-012 The block SHALL hold a circular sample buffer of taps entries, data_width bits each, and a write pointer wptr.
REQ-013 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-014 IDLE behaviour: ready_out=1, mac_init=0, rom_address=0.
REQ-015 RUN behaviour: ready_out=0.
REQ-016 An accept occurs at an edge where the FSM is IDLE and valid_in=1.
REQ-017 On an accept, the block SHALL write x_in to buffer[wptr], latch newest=wptr, set tap counter k=0, and enter RUN.
REQ-018 valid_in SHALL be ignored in RUN, with no write and no stall; the upstream block must hold x_in until ready_out=1.
REQ-019 In RUN, rom_address SHALL equal k and ram_out SHALL equal buffer[(newest-k) mod taps], i.e. x[n-k].
REQ-020 ram_out SHALL be a combinational read; rom_address and mac_init SHALL be registered.
REQ-021 mac_init SHALL be 1 exactly in the RUN cycle with k=0.
REQ-022 k SHALL increment by 1 per RUN cycle; k wraps modulo taps via the index arithmetic.
REQ-023 At k=taps-1 the FSM SHALL return to IDLE, increment wptr modulo taps, and pulse frame_done=1 in the following cycle.
REQ-024 A frame SHALL occupy exactly taps RUN cycles, starting the cycle after the accept; the next accept is possible in the first IDLE cycle.
REQ-025 Maximum throughput SHALL be one sample per taps+1 cycles.
REQ-026 In IDLE, ram_out SHALL be 0 so the downstream accumulator adds zero products and holds its result.
REQ-027 valid_in asserted in the same cycle that RUN ends SHALL NOT be accepted; it is accepted on the next edge, while IDLE, if still high.

Reset
REQ-028 reset=1 SHALL immediately force: FSM=IDLE, wptr=0, k=0, all buffer entries=0, rom_address=0, mac_init=0, frame_done=0, ram_out=0, ready_out=1.
REQ-029 Reset during RUN SHALL abort the frame with no frame_done pulse; zeroed history means the next frame uses x[n-k]=0 for unwritten taps.

Configuration
REQ-030 Macro FIR_CTRL_BYPASS_EN, when defined, SHALL add input port bypass (1 bit).
REQ-031 With FIR_CTRL_BYPASS_EN defined and bypass=1 at accept: the frame SHALL be one RUN cycle with rom_address=0, ram_out=x_in, mac_init=1.
REQ-032 That bypass frame SHALL also write the buffer and advance wptr, then pulse frame_done.
REQ-033 Without the macro, the bypass port and logic SHALL be absent and behaviour is REQ-012 to REQ-029.

Structure
REQ-034 A shared package fir_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1) and default constants FIR_TAPS=8 and FIR_DATA_WIDTH=8.
REQ-035 The sample buffer SHALL be a sub-module fir_sample_buffer: one write port, one asynchronous read port, asynchronous reset clear.

Verification
REQ-036 Reset then sample 5 with taps=8: mac_init=1 only at k=0; ram_out=5,0,0,0,0,0,0,0; frame_done one cycle after k=7.
REQ-037 Samples 1,2,3 accepted back-to-back: the third frame gives ram_out=3,2,1,0,0,0,0,0.
REQ-038 Ten samples 1..10: the 10th frame gives ram_out=10,9,...,3 (wptr wrap).
REQ-039 valid_in held high through RUN with x_in=7 then 9: only one sample is written per frame; ready_out=0 throughout RUN.
REQ-040 Reset asserted at k=3: outputs go to 0 immediately, no frame_done; a following sample 4 gives ram_out=4,0,...,0.
REQ-041 FIR_CTRL_BYPASS_EN defined, bypass=1, x_in=6: one RUN cycle with ram_out=6, mac_init=1, frame_done next cycle.
